// File: rtl/counter_multi_pkg.sv
// -----------------------------------------------------------------------------
// counter_multi_pkg
// Shared definitions for the multi-digit press counter:
//   - mode_e     : operating mode encodings driven by the mode switches
//   - DIGIT_W    : bits per hex digit
//   - cnt_width(): count width for a given number of hex digits
// -----------------------------------------------------------------------------
package counter_multi_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'b00,
        MODE_SAT  = 2'b01,
        MODE_LOAD = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam int DIGIT_W = 4;

    // Count width CNT_W = 4 * DIGITS.
    function automatic int cnt_width(input int digits);
        return DIGIT_W * digits;
    endfunction

endpackage

// File: rtl/counter_multi_btn_pulse.sv
// -----------------------------------------------------------------------------
// btn_pulse
// Turns one raw, active-low, asynchronous push button into single-cycle
// event pulses: 2-FF synchroniser, debounce filter, then auto-repeat while
// the button stays held.
//   clk100_i  in  1  system clock
//   rstn_i    in  1  asynchronous reset, active-low
//   key_n_i   in  1  raw button, 0 = pressed
//   pulse_o   out 1  one-cycle event pulse (press or auto-repeat)
// Timing: a clean press gives pulse_o 2+DEB_CYCLES cycles after the raw edge;
// further pulses follow RPT_DELAY cycles after acceptance, then every
// RPT_PERIOD cycles, until the release is accepted.
// -----------------------------------------------------------------------------
module btn_pulse #(
    parameter int DEB_CYCLES = 500000,
    parameter int RPT_DELAY  = 50000000,
    parameter int RPT_PERIOD = 10000000
) (
    input  logic clk100_i,
    input  logic rstn_i,
    input  logic key_n_i,
    output logic pulse_o
);

    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

    logic             key_s1;       // synchroniser stages, raw polarity
    logic             key_s2;
    logic             sync_pressed; // synchronised level, 1 = pressed
    logic             held;         // debounced (accepted) level, 1 = pressed
    logic [DEB_W-1:0] deb_cnt;      // consecutive cycles sync level != held
    logic [RPT_W-1:0] rpt_cnt;      // cycles since last pulse while held
    logic             rpt_first;    // next repeat uses RPT_DELAY, not RPT_PERIOD
    logic             accept;       // sync level has been stable long enough

    assign sync_pressed = ~key_s2;
    assign accept       = (sync_pressed != held) && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // Synchroniser resets to "released" so that a key held through
            // reset needs a full fresh debounce before it is accepted.
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            held      <= 1'b0;
            deb_cnt   <= '0;
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
            pulse_o   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side sees the pre-edge value and the two synchroniser stages
            // stay two separate flops.
            key_s1  <= key_n_i;
            key_s2  <= key_s1;
            pulse_o <= 1'b0;

            // Any cycle where the sync level matches the accepted level
            // (a bounce back) restarts the stability count.
            if (sync_pressed == held || accept) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            if (accept) begin
                // A release acceptance wins over a coincident repeat pulse.
                held      <= sync_pressed;
                pulse_o   <= sync_pressed;
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end else if (held) begin
                if (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
                    pulse_o   <= 1'b1;
                    rpt_cnt   <= '0;
                    rpt_first <= 1'b0;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dectohex.sv
// -----------------------------------------------------------------------------
// dectohex
// Hex digit to 7-segment decoder for the board display (active-low segments,
// bit order g..a).
//   dec_i  in  4  nibble to display
//   hex_o  out 7  segment drive, 0 = segment lit
// -----------------------------------------------------------------------------
module dectohex (
    input  logic [3:0] dec_i,
    output logic [6:0] hex_o
);

    always_comb begin
        // NOTE: default assignment before the case keeps this purely
        // combinational; a missing path would otherwise infer a latch.
        hex_o = 7'h7F;
        case (dec_i)
            4'h0: hex_o = 7'h40;
            4'h1: hex_o = 7'h79;
            4'h2: hex_o = 7'h24;
            4'h3: hex_o = 7'h30;
            4'h4: hex_o = 7'h19;
            4'h5: hex_o = 7'h12;
            4'h6: hex_o = 7'h02;
            4'h7: hex_o = 7'h78;
            4'h8: hex_o = 7'h00;
            4'h9: hex_o = 7'h10;
            4'hA: hex_o = 7'h08;
            4'hB: hex_o = 7'h03;
            4'hC: hex_o = 7'h46;
            4'hD: hex_o = 7'h21;
            4'hE: hex_o = 7'h06;
            4'hF: hex_o = 7'h0E;
            default: hex_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/counter_multi.sv
// -----------------------------------------------------------------------------
// counter_multi
// Multi-digit up/down press counter with debounced, auto-repeating buttons,
// four operating modes and a sticky overflow flag.
//   clk100_i   in  1         system clock, 100 MHz
//   rstn_i     in  1         asynchronous reset, active-low
//   sw_i       in  SW_W      switches, captured into ledr_o on events
//   key_inc_i  in  1         raw increment button, active-low, async
//   key_dec_i  in  1         raw decrement button, active-low, async
//   mode_i     in  2         00 wrap, 01 saturate, 10 load, 11 hold
//   ledr_o     out SW_W      last captured switch value
//   cnt_o      out 4*DIGITS  current count
//   ovf_o      out 1         sticky overflow/underflow flag (reset clears)
//   hex_o      out 7*DIGITS  7-segment digits, digit i = bits [7i+6:7i]
// -----------------------------------------------------------------------------
module counter_multi
    import counter_multi_pkg::*;
#(
    parameter int SW_W       = 10,
    parameter int DIGITS     = 2,
    parameter int DEB_CYCLES = 500000,
    parameter int RPT_DELAY  = 50000000,
    parameter int RPT_PERIOD = 10000000
) (
    input  logic                        clk100_i,
    input  logic                        rstn_i,
    input  logic [SW_W-1:0]             sw_i,
    input  logic                        key_inc_i,
    input  logic                        key_dec_i,
    input  logic [1:0]                  mode_i,
    output logic [SW_W-1:0]             ledr_o,
    output logic [DIGIT_W*DIGITS-1:0]   cnt_o,
    output logic                        ovf_o,
    output logic [7*DIGITS-1:0]         hex_o
);

    localparam int               CNT_W   = cnt_width(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       inc_pulse;
    logic       dec_pulse;
    logic [1:0] mode_s1;
    logic [1:0] mode_s2;
    mode_e      mode_q;

    btn_pulse #(
        .DEB_CYCLES (DEB_CYCLES),
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD)
    ) u_btn_inc (
        .clk100_i (clk100_i),
        .rstn_i   (rstn_i),
        .key_n_i  (key_inc_i),
        .pulse_o  (inc_pulse)
    );

    btn_pulse #(
        .DEB_CYCLES (DEB_CYCLES),
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD)
    ) u_btn_dec (
        .clk100_i (clk100_i),
        .rstn_i   (rstn_i),
        .key_n_i  (key_dec_i),
        .pulse_o  (dec_pulse)
    );

    assign mode_q = mode_e'(mode_s2);

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_s1 <= 2'b00;
            mode_s2 <= 2'b00;
            ledr_o  <= '0;
            cnt_o   <= '0;
            ovf_o   <= 1'b0;
        end else begin
            mode_s1 <= mode_i;
            mode_s2 <= mode_s1;

            // Exactly one pulse is an event; simultaneous inc and dec cancel.
            if ((inc_pulse ^ dec_pulse) && (mode_q != MODE_HOLD)) begin
                ledr_o <= sw_i;
                case (mode_q)
                    MODE_WRAP: begin
                        if (inc_pulse) begin
                            cnt_o <= cnt_o + 1'b1;
                            if (cnt_o == CNT_MAX) ovf_o <= 1'b1;
                        end else begin
                            cnt_o <= cnt_o - 1'b1;
                            if (cnt_o == '0) ovf_o <= 1'b1;
                        end
                    end
                    MODE_SAT: begin
                        if (inc_pulse) begin
                            if (cnt_o == CNT_MAX) ovf_o <= 1'b1;
                            else                  cnt_o <= cnt_o + 1'b1;
                        end else begin
                            if (cnt_o == '0) ovf_o <= 1'b1;
                            else             cnt_o <= cnt_o - 1'b1;
                        end
                    end
                    MODE_LOAD: begin
                        // Switch value is zero-extended or truncated to CNT_W.
                        cnt_o <= inc_pulse ? CNT_W'(sw_i) : '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_hex
        dectohex u_dectohex (
            .dec_i (cnt_o[DIGIT_W*i +: DIGIT_W]),
            .hex_o (hex_o[7*i +: 7])
        );
    end

endmodule

// File: doc/counter_multi.md
Name: counter_multi

Overview:
- Parametrised successor of the lab press counter.
- Two debounced buttons (increment, decrement), each with auto-repeat while held.
- Four selectable modes: wrap, saturate, load, hold.
- Multi-digit hex display and a sticky overflow flag.
- Sits between board I/O (switches, keys, LEDs, 7-segment) and the existing dectohex decoder.

Parameters:
- SW_W, 10, width of switch input and LED capture register.
- DIGITS, 2, number of hex digits; count width is CNT_W = 4*DIGITS.
- DEB_CYCLES, 500000, cycles a synchronised button level must stay stable before it is accepted (5 ms at 100 MHz).
- RPT_DELAY, 50000000, cycles a button must be held after acceptance before the first auto-repeat pulse.
- RPT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses.

Ports:
- clk100_i  in  1  system clock, 100 MHz.
- rstn_i  in  1  asynchronous reset, active-low; the single clock is clk100_i.
- sw_i  in  SW_W  switch value, captured on accepted events.
- key_inc_i  in  1  raw increment button, active-low (pressed = 0), asynchronous to the clock.
- key_dec_i  in  1  raw decrement button, active-low, asynchronous.
- mode_i  in  2  operating mode: 00 wrap, 01 saturate, 10 load, 11 hold. Synchronised internally.
- ledr_o  out  SW_W  last captured switch value.
- cnt_o  out  CNT_W  current count.
- ovf_o  out  1  sticky overflow/underflow flag.
- hex_o  out  7*DIGITS  segment outputs; digit i occupies bits [7i+6:7i] and shows cnt_o[4i+3:4i], with segment encoding as dectohex.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - ledr_o = 0, cnt_o = 0, ovf_o = 0; hex_o shows all digits as "0".
  - All synchronisers, debounce counters and repeat timers clear; button state = released.
  - Takes effect mid-operation, including mid-debounce or mid-repeat, with no pulse emitted. The first pulse after release of reset requires a fresh full debounce.
- Per button (btn_pulse instance):
  - 2-FF synchroniser, then debounce: the accepted level changes only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - A pressed transition of the accepted level emits a 1-cycle pulse.
  - While held, a further pulse is emitted RPT_DELAY cycles after acceptance, then one every RPT_PERIOD cycles.
  - Release stops the repeat immediately and emits no pulse.
- Latency: a clean press produces a pulse 2+DEB_CYCLES cycles after the raw edge. Registered outputs update on the clock edge after the pulse.
- Event resolution in the cycle after the pulses:
  - inc and dec pulses in the same cycle: both are ignored; no change to cnt_o, ledr_o or ovf_o.
  - A single pulse captures sw_i into ledr_o in every mode except hold.
  - Mode 00 wrap: inc gives cnt+1 mod 2^CNT_W; dec gives cnt-1 mod 2^CNT_W. Max to 0 or 0 to max sets ovf_o.
  - Mode 01 saturate: inc at max holds max; dec at 0 holds 0. Either clamped attempt sets ovf_o.
  - Mode 10 load: inc loads cnt_o = sw_i zero-extended or truncated to CNT_W; dec clears cnt_o to 0. ovf_o unchanged.
  - Mode 11 hold: pulses are ignored entirely; the debouncers keep running.
- ovf_o is cleared only by reset. A mode change does not alter cnt_o or ovf_o.
- hex_o is combinational from cnt_o.

Decomposition:
- Shared package holds the mode encodings (MODE_WRAP, MODE_SAT, MODE_LOAD, MODE_HOLD) and CNT_W = 4*DIGITS.
- Sub-module btn_pulse: synchroniser, debounce and auto-repeat, parameters DEB_CYCLES, RPT_DELAY, RPT_PERIOD. Instantiated twice.
- The existing dectohex is instantiated DIGITS times in a generate loop.

Test Plan (bench uses DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8, DIGITS=2, SW_W=10):
- Reset, then a clean inc press in wrap mode with sw_i=0x2A5 -> one pulse 6 cycles after the edge; cnt_o=0x01, ledr_o=0x2A5, hex_o shows "01", ovf_o=0.
- Bouncing inc key (three toggles under 4 cycles, then held low) -> exactly one increment; held for 60 cycles after acceptance -> pulses at acceptance+20, +28, +36, +44, +52, giving cnt_o=0x06; release -> no further change.
- Wrap mode with cnt_o=0xFF, inc -> cnt_o=0x00, ovf_o=1. Then saturate mode with cnt_o=0x00, dec -> cnt_o stays 0x00, ovf_o stays 1.
- Load mode, sw_i=0x3C7, inc -> cnt_o=0xC7, ledr_o=0x3C7; then dec -> cnt_o=0x00.
- inc and dec pulses aligned to the same cycle -> cnt_o and ledr_o unchanged. Hold mode with any press -> nothing changes.
- rstn_i asserted mid-repeat with cnt_o=0x10 -> all outputs 0 immediately, no pulse on release of reset while the key is still held until after a new debounce.
